long_multiplier: RTL

LONG_MULTIPLIER -- requirements
Module: long_multiplier

---
 rtl/long_div_pkg.sv | 13 +
 rtl/long_multiplier_if.sv | 40 ++++
 rtl/long_multiplier_dp.sv | 61 ++++++
 rtl/long_multiplier.sv | 108 ++++++++++
 4 files changed

// File: rtl/long_div_pkg.sv
// Shared definitions for the shift-add multiplier that rebuilds a dividend
// from divisor, quotient and remainder.
package long_div_pkg;

  localparam int W_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/long_multiplier_if.sv
// Operand/result handshake bundle for long_multiplier; the D/mismatch check
// pair exists only when LONG_MULTIPLIER_CHECK_EN is defined.
interface long_multiplier_if import long_div_pkg::*; #(
  parameter int W = W_DEFAULT
);

  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   M;
  logic [W-1:0]   Q;
  logic [W-1:0]   R;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] P;
`ifdef LONG_MULTIPLIER_CHECK_EN
  logic [2*W-2:0] D;
  logic           mismatch;

  modport master (
    output in_valid, M, Q, R, D, out_ready,
    input  in_ready, out_valid, P, mismatch
  );

  modport slave (
    input  in_valid, M, Q, R, D, out_ready,
    output in_ready, out_valid, P, mismatch
  );
`else
  modport master (
    output in_valid, M, Q, R, out_ready,
    input  in_ready, out_valid, P
  );

  modport slave (
    input  in_valid, M, Q, R, out_ready,
    output in_ready, out_valid, P
  );
`endif

endinterface

// File: rtl/long_multiplier_dp.sv
// Shift-add datapath: accumulator, multiplier shift register, bit counter
// and the adder that folds one partial product in per step.
module long_multiplier_dp import long_div_pkg::*; #(
  parameter int W = W_DEFAULT
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load,
  input  logic           step,
  input  logic [W-1:0]   m_in,
  input  logic [W-1:0]   q_in,
  input  logic [W-1:0]   r_in,
  output logic           last,
  output logic [2*W-1:0] sum
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]   m_r;
  logic [W-1:0]   q_r;
  logic [2*W-1:0] acc_r;
  logic [CW-1:0]  count_r;
  logic [2*W-1:0] addend_s;

  // Partial product for the current multiplier bit, aligned by the count.
  always_comb begin
    addend_s = {(2*W){1'b0}};
    if (q_r[0]) begin
      addend_s = {{W{1'b0}}, m_r} << count_r;
    end else begin
      addend_s = {(2*W){1'b0}};
    end
  end

  assign sum  = acc_r + addend_s;
  assign last = (count_r == CW'(W - 1));

  // Operand capture on load, one multiplier bit consumed per step.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_r     <= {W{1'b0}};
      q_r     <= {W{1'b0}};
      acc_r   <= {(2*W){1'b0}};
      count_r <= {CW{1'b0}};
    end else if (load) begin
      m_r     <= m_in;
      q_r     <= q_in;
      acc_r   <= {{W{1'b0}}, r_in};
      count_r <= {CW{1'b0}};
    end else if (step) begin
      acc_r   <= sum;
      q_r     <= q_r >> 1;
      count_r <= count_r + CW'(1);
    end else begin
      acc_r   <= acc_r;
      q_r     <= q_r;
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/long_multiplier.sv
// Sequential P = Q*M + R with valid/ready on both sides, fixed W-cycle latency.
// Optional self-check against an expected dividend: LONG_MULTIPLIER_CHECK_EN.
module long_multiplier import long_div_pkg::*; #(
  parameter int W = W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  long_multiplier_if.slave  bus
);

  state_t         state_r;
  state_t         state_s;
  logic           in_ready_r;
  logic           out_valid_r;
  logic [2*W-1:0] p_r;
  logic           accept_s;
  logic           release_s;
  logic           finish_s;
  logic           last_s;
  logic [2*W-1:0] sum_s;

  assign accept_s  = (state_r == IDLE) && bus.in_valid;
  assign release_s = out_valid_r && bus.out_ready;
  assign finish_s  = (state_r == RUN) && last_s;

  long_multiplier_dp #(.W(W)) u_dp (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (accept_s),
    .step  (state_r == RUN),
    .m_in  (bus.M),
    .q_in  (bus.Q),
    .r_in  (bus.R),
    .last  (last_s),
    .sum   (sum_s)
  );

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    if (accept_s)  state_s = RUN;  else state_s = IDLE;
      RUN:     if (last_s)    state_s = DONE; else state_s = RUN;
      DONE:    if (release_s) state_s = IDLE; else state_s = DONE;
      default: state_s = IDLE;
    endcase
  end

  // State plus handshake flags registered from the next state; P latched on completion.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      p_r         <= {(2*W){1'b0}};
    end else begin
      state_r     <= state_s;
      in_ready_r  <= (state_s == IDLE);
      out_valid_r <= (state_s == DONE);
      if (finish_s) begin
        p_r <= sum_s;
      end else begin
        p_r <= p_r;
      end
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.P         = p_r;

`ifdef LONG_MULTIPLIER_CHECK_EN
  logic [2*W-2:0] d_r;
  logic [W-1:0]   m_chk_r;
  logic [W-1:0]   r_chk_r;
  logic           mismatch_r;

  // Flag a wrong dividend or an out-of-range remainder for the whole DONE phase.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      d_r        <= {(2*W-1){1'b0}};
      m_chk_r    <= {W{1'b0}};
      r_chk_r    <= {W{1'b0}};
      mismatch_r <= 1'b0;
    end else begin
      if (accept_s) begin
        d_r     <= bus.D;
        m_chk_r <= bus.M;
        r_chk_r <= bus.R;
      end else begin
        d_r     <= d_r;
        m_chk_r <= m_chk_r;
        r_chk_r <= r_chk_r;
      end
      if (state_s != DONE) begin
        mismatch_r <= 1'b0;
      end else if (finish_s) begin
        mismatch_r <= (sum_s != {1'b0, d_r}) || (r_chk_r >= m_chk_r);
      end else begin
        mismatch_r <= mismatch_r;
      end
    end
  end

  assign bus.mismatch = mismatch_r;
`endif

endmodule
